fft8_bf_sequencer: RTL

//  Sequences one shared radix-2 butterfly unit through a full 8-point DIT FFT.

---
 rtl/fft8_pkg.sv | 26 ++
 rtl/fft8_bf_sequencer_if.sv | 46 ++++
 rtl/fft8_addr_gen.sv | 41 ++++
 rtl/fft8_bf_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point radix-2 DIT FFT butterfly sequencer:
// frame geometry, controller state encoding, twiddle codes and the
// bit-reversal helper used when loading samples.
package fft8_pkg;

  localparam int NPTS   = 8;
  localparam int STAGES = 3;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  // Twiddle select k means W8^k.
  localparam logic [1:0] TW_W0 = 2'd0;  // 1
  localparam logic [1:0] TW_W1 = 2'd1;  // (1-i)/sqrt2
  localparam logic [1:0] TW_W2 = 2'd2;  // -i
  localparam logic [1:0] TW_W3 = 2'd3;  // (-1-i)/sqrt2

  // Bit-reversed index of a 3-bit sample number.
  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

endpackage

// File: rtl/fft8_bf_sequencer_if.sv
// Bundle of the sample-in stream, result-out stream, status and the
// port pair to the external combinational butterfly.
// slave: sequencer view; master: environment (source, sink, butterfly) view.
interface fft8_bf_sequencer_if #(
  parameter int N = 3
);
  localparam int W = 2 ** N;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_r;
  logic [W-1:0] in_i;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  logic [W-1:0] out_i;
  logic [2:0]   out_idx;

  logic         busy;

  logic [W-1:0] bf_a_r;
  logic [W-1:0] bf_a_i;
  logic [W-1:0] bf_b_r;
  logic [W-1:0] bf_b_i;
  logic [1:0]   bf_tw;
  logic [W-1:0] bf_y1_r;
  logic [W-1:0] bf_y1_i;
  logic [W-1:0] bf_y2_r;
  logic [W-1:0] bf_y2_i;

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
           bf_y1_r, bf_y1_i, bf_y2_r, bf_y2_i,
    output in_ready, out_valid, out_r, out_i, out_idx, busy,
           bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_tw
  );

  modport master (
    output in_valid, in_r, in_i, out_ready,
           bf_y1_r, bf_y1_i, bf_y2_r, bf_y2_i,
    input  in_ready, out_valid, out_r, out_i, out_idx, busy,
           bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_tw
  );

endinterface

// File: rtl/fft8_addr_gen.sv
// Butterfly address generator for the 8-point DIT FFT:
// (stage s, butterfly k) -> operand addresses a, b and twiddle code,
// with span = 1<<s, j = k % span, a = (k/span)*2*span + j, b = a + span,
// tw = j * (4 >> s). Purely combinational.
module fft8_addr_gen
  import fft8_pkg::*;
(
  input  logic [1:0] stage,
  input  logic [1:0] bfly,
  output logic [2:0] addr_a,
  output logic [2:0] addr_b,
  output logic [1:0] tw
);

  // Per-stage bit placement of k into the address pair and twiddle.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    addr_a = 3'd0;
    addr_b = 3'd0;
    tw     = TW_W0;
    case (stage)
      2'd0: begin
        addr_a = {bfly, 1'b0};
        addr_b = {bfly, 1'b1};
        tw     = TW_W0;
      end
      2'd1: begin
        addr_a = {bfly[1], 1'b0, bfly[0]};
        addr_b = {bfly[1], 1'b1, bfly[0]};
        tw     = bfly[0] ? TW_W2 : TW_W0;
      end
      2'd2: begin
        addr_a = {1'b0, bfly};
        addr_b = {1'b1, bfly};
        tw     = bfly;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fft8_bf_sequencer.sv
// 8-point radix-2 DIT FFT sequencer around one shared external butterfly.
// LOAD: 8 samples stored bit-reversed; COMPUTE: 3 stages x 4 butterflies
// in place; UNLOAD: bins streamed out in natural order.
// Build option FFT8_SEQ_BF_REG_EN: butterfly results are registered once
// before write-back, so each butterfly takes an issue and a write cycle.
module fft8_bf_sequencer
  import fft8_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fft8_bf_sequencer_if.slave   bus
);

  localparam int W = 2 ** N;

  state_t       state;
  state_t       state_nx;

  logic [2:0]   load_cnt;
  logic [2:0]   out_cnt;
  logic [1:0]   stage;
  logic [1:0]   bfly;

  logic [W-1:0] buf_r [NPTS];
  logic [W-1:0] buf_i [NPTS];

  logic [2:0]   addr_a;
  logic [2:0]   addr_b;
  logic [1:0]   tw;

  logic         load_fire;
  logic         out_fire;
  logic         bf_wr;
  logic         compute_done;

  logic [W-1:0] wr_a_r, wr_a_i, wr_b_r, wr_b_i;
  logic [W-1:0] hold_a_r, hold_a_i, hold_b_r, hold_b_i;
  logic [1:0]   hold_tw;

  fft8_addr_gen u_addr_gen (
    .stage  (stage),
    .bfly   (bfly),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .tw     (tw)
  );

  assign load_fire = (state == ST_LOAD) && bus.in_valid;
  assign out_fire  = (state == ST_UNLOAD) && bus.out_ready;

`ifdef FFT8_SEQ_BF_REG_EN
  logic         phase;
  logic [W-1:0] y1_r_q, y1_i_q, y2_r_q, y2_i_q;

  // Issue/write phase toggle; restarts at issue on every COMPUTE entry.
  always_ff @(posedge clk) begin
    if (rst)
      phase <= 1'b0;
    else if (state == ST_COMPUTE)
      phase <= ~phase;
    else
      phase <= 1'b0;
  end

  // Capture butterfly results at the end of the issue cycle.
  always_ff @(posedge clk) begin
    if (state == ST_COMPUTE && !phase) begin
      y1_r_q <= bus.bf_y1_r;
      y1_i_q <= bus.bf_y1_i;
      y2_r_q <= bus.bf_y2_r;
      y2_i_q <= bus.bf_y2_i;
    end
  end

  assign bf_wr  = (state == ST_COMPUTE) && phase;
  assign wr_a_r = y1_r_q;
  assign wr_a_i = y1_i_q;
  assign wr_b_r = y2_r_q;
  assign wr_b_i = y2_i_q;
`else
  assign bf_wr  = (state == ST_COMPUTE);
  assign wr_a_r = bus.bf_y1_r;
  assign wr_a_i = bus.bf_y1_i;
  assign wr_b_r = bus.bf_y2_r;
  assign wr_b_i = bus.bf_y2_i;
`endif

  assign compute_done = bf_wr && (stage == 2'd2) && (bfly == 2'd3);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst)
      state <= ST_LOAD;
    else
      state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:    if (load_fire && load_cnt == 3'd7) state_nx = ST_COMPUTE;
      ST_COMPUTE: if (compute_done)                  state_nx = ST_UNLOAD;
      ST_UNLOAD:  if (out_fire && out_cnt == 3'd7)   state_nx = ST_LOAD;
      default:                                       state_nx = ST_LOAD;
    endcase
  end

  // Load, butterfly/stage and output counters; all wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= 3'd0;
      out_cnt  <= 3'd0;
      stage    <= 2'd0;
      bfly     <= 2'd0;
    end else begin
      if (load_fire)
        load_cnt <= load_cnt + 3'd1;
      if (bf_wr) begin
        bfly <= bfly + 2'd1;
        if (bfly == 2'd3)
          stage <= (stage == 2'd2) ? 2'd0 : stage + 2'd1;
      end
      if (out_fire)
        out_cnt <= out_cnt + 3'd1;
    end
  end

  // Sample buffer: bit-reversed load writes, in-place butterfly write-back.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; every entry is written before it is read in a frame.
    if (load_fire) begin
      buf_r[bitrev3(load_cnt)] <= bus.in_r;
      buf_i[bitrev3(load_cnt)] <= bus.in_i;
    end else if (bf_wr) begin
      buf_r[addr_a] <= wr_a_r;
      buf_i[addr_a] <= wr_a_i;
      buf_r[addr_b] <= wr_b_r;
      buf_i[addr_b] <= wr_b_i;
    end
  end

  // Last issued butterfly operands, held so bf_* stay quiet outside COMPUTE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_a_r <= '0;
      hold_a_i <= '0;
      hold_b_r <= '0;
      hold_b_i <= '0;
      hold_tw  <= TW_W0;
    end else if (state == ST_COMPUTE) begin
      hold_a_r <= buf_r[addr_a];
      hold_a_i <= buf_i[addr_a];
      hold_b_r <= buf_r[addr_b];
      hold_b_i <= buf_i[addr_b];
      hold_tw  <= tw;
    end
  end

  assign bus.bf_a_r = (state == ST_COMPUTE) ? buf_r[addr_a] : hold_a_r;
  assign bus.bf_a_i = (state == ST_COMPUTE) ? buf_i[addr_a] : hold_a_i;
  assign bus.bf_b_r = (state == ST_COMPUTE) ? buf_r[addr_b] : hold_b_r;
  assign bus.bf_b_i = (state == ST_COMPUTE) ? buf_i[addr_b] : hold_b_i;
  assign bus.bf_tw  = (state == ST_COMPUTE) ? tw            : hold_tw;

  assign bus.in_ready  = (state == ST_LOAD);
  assign bus.out_valid = (state == ST_UNLOAD);
  assign bus.busy      = (state != ST_LOAD);
  assign bus.out_idx   = out_cnt;
  assign bus.out_r     = (state == ST_UNLOAD) ? buf_r[out_cnt] : '0;
  assign bus.out_i     = (state == ST_UNLOAD) ? buf_i[out_cnt] : '0;

endmodule
